// File: rtl/cpu_sequencer.sv
// cpu_sequencer: boot-load, run-control and instruction sequencing for the 8-bit CPU.
// Define CPU_SEQ_TIMEOUT_EN to enable the fetch watchdog that sends a stuck FETCH to FAULT.
module cpu_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int BOOT_LEN = 256,
  parameter int CNT_W    = 16,
  parameter int FETCH_TO = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              flash_valid,
  input  logic              fetch_ready,
  input  logic [1:0]        instr_len,
  input  logic              exec_busy,
  input  logic              halt_req,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              flash_strt,
  output logic              pram_wre,
  output logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              dec_en,
  output logic              exec_en,
  output logic              wb_en,
  output logic [3:0]        state_o,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);
  localparam logic [3:0] S_RESET = 4'd0, S_LOAD = 4'd1, S_IDLE = 4'd2, S_FETCH = 4'd3,
                         S_DECODE = 4'd4, S_EXECUTE = 4'd5, S_WRITEBACK = 4'd6,
                         S_HALT = 4'd7, S_FAULT = 4'd8;
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BOOT_LEN - 1);

  logic [3:0]        r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, r_pc;
  logic [CNT_W-1:0]  r_retired;
  logic              r_start_q, r_load_seen;
  logic              w_start_rise, w_wd_hit;
  logic [1:0]        w_len;

  assign w_start_rise = start && !r_start_q;
  assign w_len        = (instr_len == 2'd0) ? 2'd1 : instr_len;

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(FETCH_TO + 1);
  logic [WD_W-1:0] r_wd;
  // Zero outside FETCH, so every FETCH entry starts a fresh count
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) r_wd <= '0;
    else         r_wd <= (r_state == S_FETCH) ? r_wd + WD_W'(1) : '0;
  assign w_wd_hit = (r_state == S_FETCH) && (r_wd == WD_W'(FETCH_TO - 1));
`else
  // FETCH waits indefinitely; the limit never fires
  assign w_wd_hit = (FETCH_TO < 0);
`endif

  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) r_state <= S_RESET;
    else         r_state <= w_next;

  always_comb begin
    w_next = S_RESET;
    case (r_state)
      S_RESET:     w_next = S_LOAD;
      S_LOAD:      w_next = (flash_valid && r_cnt == LAST_BEAT) ? S_IDLE : S_LOAD;
      S_IDLE:      w_next = w_start_rise ? S_FETCH : S_IDLE;
      S_FETCH:     w_next = fetch_ready ? S_DECODE : w_wd_hit ? S_FAULT : S_FETCH;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = exec_busy ? S_EXECUTE : S_WRITEBACK;
      S_WRITEBACK: w_next = halt_req ? S_HALT : step_mode ? S_IDLE : S_FETCH;
      S_HALT:      w_next = w_start_rise ? S_FETCH : S_HALT;
      S_FAULT:     w_next = S_FAULT;
      default:     w_next = S_RESET;
    endcase
  end

  always_comb begin
    flash_strt = (r_state == S_LOAD) && !r_load_seen;
    pram_wre   = (r_state == S_LOAD) && flash_valid;
    dec_en     = r_state == S_DECODE;
    exec_en    = r_state == S_EXECUTE;
    wb_en      = r_state == S_WRITEBACK;
    halted     = r_state == S_HALT;
`ifdef CPU_SEQ_TIMEOUT_EN
    fault      = r_state == S_FAULT;
`else
    fault      = 1'b0;
`endif
  end

  // LOAD is only entered from RESET, so r_load_seen is low on the first LOAD cycle only
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      r_start_q   <= 1'b0;
      r_load_seen <= 1'b0;
      r_cnt       <= '0;
      r_pc        <= '0;
      r_retired   <= '0;
    end else begin
      r_start_q   <= start;
      r_load_seen <= r_state == S_LOAD;
      if (r_state == S_LOAD && flash_valid)
        r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + ADDR_W'(1);
      if (r_state == S_WRITEBACK) begin
        r_pc      <= jmp_en ? jmp_addr : r_pc + ADDR_W'(w_len);
        r_retired <= (&r_retired) ? r_retired : r_retired + CNT_W'(1);
      end
    end

  assign load_addr = r_cnt;
  assign pc        = r_pc;
  assign retired   = r_retired;
  assign state_o   = r_state;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed instruction table plus randomized runs against an instruction-level model.
module tb_cpu_sequencer;
  localparam int AW = 8, BL = 4, CW = 4, TO = 8, RMAX = 15;

  logic          sys_clk = 1'b0, sys_rst = 1'b0;
  logic          start = 1'b0, step_mode = 1'b0, flash_valid = 1'b0, fetch_ready = 1'b0;
  logic          exec_busy = 1'b0, halt_req = 1'b0, jmp_en = 1'b0;
  logic [1:0]    instr_len = 2'd0;
  logic [AW-1:0] jmp_addr = '0;
  logic          flash_strt, pram_wre, dec_en, exec_en, wb_en, halted, fault;
  logic [AW-1:0] load_addr, pc;
  logic [3:0]    state_o;
  logic [CW-1:0] retired;

  cpu_sequencer #(.ADDR_W(AW), .BOOT_LEN(BL), .CNT_W(CW), .FETCH_TO(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .step_mode(step_mode),
    .flash_valid(flash_valid), .fetch_ready(fetch_ready), .instr_len(instr_len),
    .exec_busy(exec_busy), .halt_req(halt_req), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .flash_strt(flash_strt), .pram_wre(pram_wre), .load_addr(load_addr), .pc(pc),
    .dec_en(dec_en), .exec_en(exec_en), .wb_en(wb_en), .state_o(state_o),
    .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0] len;
    logic       jmp;
    logic [7:0] addr;
    int         busy;
    int         waits;
    logic       step;
    logic       halt;
    logic [7:0] exp_pc;
    int         exp_st;
    int         exp_cyc;
  } vec_t;

  vec_t          tbl[9];
  int            n_cmp = 0, n_err = 0, cyc = 0, n_ret = 0;
  logic [AW-1:0] m_pc = '0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, a, e, $time);
    end
  endtask

  // Strobes are a pure function of the architectural state name
  task automatic exp_out(input int st, input logic fs, input logic pw, input int la);
    logic [10:0] ev;
    ev = {4'(st), fs, pw, st == 4, st == 5, st == 6, st == 7, st == 8};
    chk($sformatf("outputs_st%0d", st),
        32'({state_o, flash_strt, pram_wre, dec_en, exec_en, wb_en, halted, fault}), 32'(ev));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("retired", 32'(retired), (n_ret > RMAX) ? RMAX : n_ret);
    chk("load_addr", 32'(load_addr), la);
  endtask

  task automatic junk();
    start       = 1'($urandom);
    step_mode   = 1'($urandom);
    flash_valid = 1'($urandom);
    fetch_ready = 1'($urandom);
    exec_busy   = 1'($urandom);
    halt_req    = 1'($urandom);
    jmp_en      = 1'($urandom);
    instr_len   = 2'($urandom);
    jmp_addr    = 8'($urandom);
  endtask

  task automatic run_instr(input vec_t v);
    for (int i = 0; i <= v.waits; i++) begin
      junk(); fetch_ready = (i == v.waits); #1 exp_out(3, 0, 0, 0); tick();
    end
    junk(); #1 exp_out(4, 0, 0, 0); tick();
    for (int i = 0; i <= v.busy; i++) begin
      junk(); exec_busy = (i < v.busy); #1 exp_out(5, 0, 0, 0); tick();
    end
    junk();
    instr_len = v.len; jmp_en = v.jmp; jmp_addr = v.addr; step_mode = v.step; halt_req = v.halt;
    #1 exp_out(6, 0, 0, 0);
    tick();
    n_ret++;
    m_pc = v.jmp ? v.addr : m_pc + 8'((v.len == 2'd0) ? 1 : int'(v.len));
  endtask

  task automatic resume(input int st);
    junk(); start = 1'b0; #1 exp_out(st, 0, 0, 0); tick();
    junk(); start = 1'b1; #1 exp_out(st, 0, 0, 0); tick();
  endtask

  // Flash beats on every other cycle; abort_at < BL asserts reset once that many beats landed
  task automatic boot(input int abort_at);
    int got, c;
    got = 0; c = 0;
    junk(); flash_valid = 1'b0; sys_rst = 1'b0;
    #1 exp_out(0, 0, 0, 0);
    tick();
    while (got < BL && c < 40) begin
      junk(); flash_valid = 1'(c % 2);
      #1 exp_out(1, c == 0, flash_valid, got);
      if (got == abort_at) begin
        sys_rst = 1'b1;
        #1 exp_out(0, 0, 0, 0);
        return;
      end
      got += int'(flash_valid);
      c++;
      tick();
    end
    chk("boot_cycles", c, 2 * BL);
    junk();
    #1 exp_out(2, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not finish, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   c0;
    tbl[0] = '{2'd2, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 8'h02, 3, 4};
    tbl[1] = '{2'd2, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 8'h04, 3, 4};
    tbl[2] = '{2'd2, 1'b0, 8'h00, 3, 0, 1'b0, 1'b0, 8'h06, 3, 7};
    tbl[3] = '{2'd1, 1'b1, 8'hFE, 0, 0, 1'b0, 1'b0, 8'hFE, 3, 4};
    tbl[4] = '{2'd3, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 8'h01, 3, 4};
    tbl[5] = '{2'd0, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 8'h02, 3, 4};
    tbl[6] = '{2'd1, 1'b0, 8'h00, 0, 2, 1'b0, 1'b0, 8'h03, 3, 6};
    tbl[7] = '{2'd2, 1'b0, 8'h00, 0, 0, 1'b1, 1'b0, 8'h05, 2, 4};
    tbl[8] = '{2'd1, 1'b1, 8'h40, 0, 0, 1'b1, 1'b1, 8'h40, 7, 4};

    sys_rst = 1'b1;
    tick(); tick();
    #1 exp_out(0, 0, 0, 0);
    boot(2);
    tick();
    boot(99);
    resume(2);

    for (int i = 0; i < 9; i++) begin
      c0 = cyc;
      run_instr(tbl[i]);
      chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
      chk($sformatf("tbl%0d_state", i), 32'(state_o), tbl[i].exp_st);
      chk($sformatf("tbl%0d_cycles", i), cyc - c0, tbl[i].exp_cyc);
      if (tbl[i].exp_st != 3) resume(tbl[i].exp_st);
    end
    chk("halt_resume_pc", 32'(pc), 32'h40);
    chk("halt_resume_state", 32'(state_o), 3);

    for (int k = 0; k < 20; k++) begin
      v.len   = 2'($urandom);
      v.jmp   = ($urandom % 4) == 0;
      v.addr  = 8'($urandom);
      v.busy  = int'($urandom % 4);
      v.waits = int'($urandom % 4);
      v.step  = ($urandom % 5) == 0;
      v.halt  = ($urandom % 8) == 0;
      run_instr(v);
      chk("rnd_next_state", 32'(state_o), v.halt ? 7 : v.step ? 2 : 3);
      if (state_o != 4'd3) resume(v.halt ? 7 : v.step ? 2 : 3);
    end
    chk("retired_saturated", 32'(retired), RMAX);

`ifdef CPU_SEQ_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      junk(); fetch_ready = 1'b0; #1 exp_out(3, 0, 0, 0); tick();
    end
    for (int i = 0; i < 5; i++) begin
      junk(); #1 exp_out(8, 0, 0, 0); tick();
    end
    sys_rst = 1'b1; m_pc = '0; n_ret = 0;
    #1 exp_out(0, 0, 0, 0);
    tick();
    boot(99);
    resume(2);
`else
    for (int i = 0; i < 100; i++) begin
      junk(); fetch_ready = 1'b0; #1 exp_out(3, 0, 0, 0); tick();
    end
`endif
    junk(); fetch_ready = 1'b1; #1 exp_out(3, 0, 0, 0); tick();
    junk(); #1 exp_out(4, 0, 0, 0); tick();
    junk(); exec_busy = 1'b1; #1 exp_out(5, 0, 0, 0);
    sys_rst = 1'b1; m_pc = '0; n_ret = 0;
    #1 exp_out(0, 0, 0, 0);
    tick();
    boot(99);
    resume(2);
    run_instr('{2'd2, 1'b0, 8'h00, 1, 0, 1'b0, 1'b0, 8'h02, 3, 5});
    chk("reboot_pc", 32'(pc), 32'h02);
    chk("reboot_retired", 32'(retired), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
